msg_arbiter: RTL and testbench
==============================

# msg_arbiter

Round-robin scheduler that shares one `Message_process` instance among four requesters. Each requester presents a 5-bit message and a request. The arbiter grants one requester at a time, drives the processor's `msg`/`start` inputs with a single start pulse, and holds the resource until the processor reports completion or a hold timeout expires. It sits directly in front of `Message_process`, replacing the bench-driven `msg`/`start`.

## Interface
- `HOLD_CYCLES`, default 100000: maximum cycles spent in WAIT per grant (1 ms at 10 ns clock). Legal range 1..2^20-1.
- `CNT_W`, default 20: width of the hold counter. Must satisfy 2^CNT_W > HOLD_CYCLES.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset; clears all state immediately.
- `req`  in  4  per-requester request level; held high until that requester's `ack`.
- `req_msg`  in  20  requester i's message on bits [5i+4:5i].
- `proc_done`  in  1  completion pulse from the message processor.
- `msg`  out  5  message to the processor; stable from ISSUE until return to IDLE.
- `start`  out  1  one-cycle start pulse to the processor.
- `ack`  out  4  one-hot, one-cycle grant acknowledge to the winning requester.
- `busy`  out  1  high in ISSUE and WAIT.
- `owner`  out  2  index of the current or last granted requester.

## Operation
- FSM states:
  - IDLE: arbitration; `busy`=0.
  - ISSUE: `start`=1 and `ack[owner]`=1 for exactly one cycle.
  - WAIT: processor owned by `owner`; hold counter runs.
- **IDLE → ISSUE** when `req` ≠ 0. On that edge:
  - winner w = first set bit of `req` scanning `ptr`, `ptr`+1, … mod 4;
  - latch `msg` ← `req_msg[5w+4:5w]`, `owner` ← w, `ptr` ← (w+1) mod 4.
- **ISSUE → WAIT** unconditionally. Counter is cleared to 0.
- **WAIT → IDLE** on the first cycle where `proc_done`=1, or where counter = HOLD_CYCLES-1. Otherwise the counter increments by 1.
- `proc_done` is ignored in IDLE and ISSUE. No counter overflow is possible within the legal range.
- `req` is sampled only in IDLE. Requests raised or dropped during ISSUE/WAIT have no effect until the next IDLE cycle.
- A requester that drops `req` before winning is simply not granted; nothing is queued.
- `msg` and `owner` keep their last values in IDLE.
- All outputs are registered.
- Reset values: `msg`=0, `start`=0, `ack`=0, `busy`=0, `owner`=0, `ptr`=0, counter=0, state IDLE.

## Timing
- Request to grant: `req[w]` high in IDLE cycle N → `ack[w]`, `start`, `busy` high in cycle N+1, with `msg` valid in the same cycle.
- `start` and `ack` are high in cycle N+1 only. WAIT begins at cycle N+2.
- Done path: `proc_done` high in WAIT cycle M → IDLE (`busy`=0) in cycle M+1.
- Timeout path: with no `proc_done`, WAIT lasts exactly HOLD_CYCLES cycles. `busy` is therefore high for HOLD_CYCLES+1 cycles.
- Minimum IDLE gap is one cycle between grants. Back-to-back grants are separated by at least one `busy`=0 cycle.
- Simultaneous requests: exactly one winner per grant, chosen by the rotating pointer. No requester waits more than 3 grants.
- Reset mid-operation (asserted in any state): outputs go to reset values asynchronously. Any `start`/`ack` pulse in flight is truncated. The state after release is IDLE with `ptr`=0.

## Test plan
- Single request: after reset, `req`=0001 with `req_msg[4:0]`=01010 → the next cycle shows `ack`=0001, `start`=1, `msg`=01010, `owner`=0. `busy` stays high until `proc_done`.
- Round-robin, HOLD_CYCLES=4, all four `req` held high, each `req[i]` dropped after its ack → grant order 0,1,2,3. Each `busy` window is 5 cycles, followed by one idle cycle.
- Timeout, HOLD_CYCLES=8, `proc_done` tied low → `busy` high for exactly 9 cycles. Exactly one `start` pulse occurs.
- Early done: `proc_done` pulsed in the 3rd WAIT cycle → `busy` falls on the next cycle. A pending `req`=0100 is then granted after the one-cycle IDLE gap, with `msg`=`req_msg[14:10]`.
- Pointer rotation: grant 2 first, then raise `req`=0101 → requester 0 is granted next (scan order 3,0,1,2).
- Reset mid-WAIT: `rst` asserted while `busy`=1, `msg`=10011 → same cycle `msg`=0, `busy`=0, `start`=0. After release, `req`=1000 is granted with `ptr` starting at 0.

Source files
------------

// File: rtl/msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : msg_arbiter
// Purpose  : Round-robin scheduler sharing one message processor among four
//            requesters. Grants one requester at a time, issues a single start
//            pulse with the winner's message, then holds the processor until
//            it reports completion or a hold timeout expires.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-high reset
//            req[3:0]   - per-requester request level
//            req_msg    - requester i message on bits [5i+4:5i]
//            proc_done  - completion pulse from the processor
//            msg[4:0]   - message to the processor (held from ISSUE to IDLE)
//            start      - one-cycle start pulse to the processor
//            ack[3:0]   - one-hot, one-cycle grant acknowledge
//            busy       - high while the processor is owned (ISSUE/WAIT)
//            owner[1:0] - index of current or last granted requester
// Revision : 1.0 - initial release
// ============================================================================
module msg_arbiter #(
  parameter int HOLD_CYCLES = 100000,
  parameter int CNT_W       = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [19:0] req_msg,
  input  logic        proc_done,
  output logic [4:0]  msg,
  output logic        start,
  output logic [3:0]  ack,
  output logic        busy,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  // Winner selection: first set request scanning from ptr upward, mod 4.
  logic [1:0] win;
  logic [1:0] scan_idx;
  logic       found;
  logic [4:0] win_msg;

  always_comb begin
    win      = ptr;
    found    = 1'b0;
    scan_idx = ptr;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr + 2'(k);
      if (!found && req[scan_idx]) begin
        win   = scan_idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win_msg = req_msg[4:0];
    case (win)
      2'd0:    win_msg = req_msg[4:0];
      2'd1:    win_msg = req_msg[9:5];
      2'd2:    win_msg = req_msg[14:10];
      default: win_msg = req_msg[19:15];
    endcase
  end

  wire hold_expired = (cnt == CNT_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= '0;
      msg   <= 5'd0;
      start <= 1'b0;
      ack   <= 4'd0;
      busy  <= 1'b0;
      owner <= 2'd0;
    end else begin
      // start/ack are pulses: default low, raised only on the grant edge.
      start <= 1'b0;
      ack   <= 4'd0;
      case (state)
        IDLE: begin
          if (found) begin
            msg   <= win_msg;
            owner <= win;
            ptr   <= win + 2'd1;
            start <= 1'b1;
            ack   <= 4'b0001 << win;
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Counter value k means this is the (k+1)-th WAIT cycle, so the
          // timeout exit happens after exactly HOLD_CYCLES WAIT cycles.
          if (proc_done || hold_expired) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msg_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
module tb_msg_arbiter;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] req_msg;
  logic        proc_done;
  logic [4:0]  msg;
  logic        start;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  msg_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_msg   (req_msg),
    .proc_done (proc_done),
    .msg       (msg),
    .start     (start),
    .ack       (ack),
    .busy      (busy),
    .owner     (owner)
  );

  // Behavioural model: a grant "age" counts cycles since the grant edge
  // (0 = start/ack cycle, 1..HOLD = holding cycles).
  logic [1:0] m_ptr, m_owner;
  logic [4:0] m_msg;
  logic       m_busy, m_start;
  logic [3:0] m_ack;
  int         m_age;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_owner = 0; m_msg = 0; m_busy = 0; m_start = 0; m_ack = 0; m_age = 0;
    end else begin
      m_start = 0;
      m_ack   = 0;
      if (!m_busy) begin
        if (req != 4'd0) begin
          int w;
          w = -1;
          for (int k = 0; k < 4; k++)
            if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
          m_owner  = 2'(w);
          m_msg    = req_msg[5*w +: 5];
          m_ptr    = 2'((w + 1) % 4);
          m_busy   = 1;
          m_start  = 1;
          m_ack[w] = 1'b1;
          m_age    = 0;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (proc_done || m_age == HOLD) begin
        m_busy = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (cmp_en)
      check("cycle_vs_model", {19'd0, msg, start, ack, busy, owner},
            {19'd0, m_msg, m_start, m_ack, m_busy, m_owner});

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles from the current (busy) cycle until busy falls.
  task automatic measure_busy(output int n, output int starts);
    n = 0;
    starts = 0;
    while (busy && n < 60) begin
      n++;
      if (start) starts++;
      step();
    end
  endtask

  task automatic wait_ack(input string name);
    int i;
    i = 0;
    while (ack == 4'd0 && i < 60) begin
      step();
      i++;
    end
    if (ack == 4'd0) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n, s;
    rst = 1'b1; req = 4'd0; req_msg = 20'd0; proc_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    check("reset_outputs", {19'd0, msg, start, ack, busy, owner}, 32'd0);

    // Single request, then early done with a pending request 2.
    req_msg[4:0]   = 5'b01010;
    req_msg[14:10] = 5'b10110;
    req = 4'b0001;
    step();
    check("single_ack",   ack,   4'b0001);
    check("single_start", start, 1);
    check("single_msg",   msg,   5'b01010);
    check("single_owner", owner, 0);
    check("single_busy",  busy,  1);
    req = 4'b0100;
    step();
    check("pulse_end", {start, ack}, 5'd0);
    check("wait_busy", busy, 1);
    step();
    step();
    proc_done = 1'b1;          // 3rd WAIT cycle
    step();
    proc_done = 1'b0;
    check("early_done_busy", busy, 0);
    step();
    check("pending_ack",   ack,   4'b0100);
    check("pending_msg",   msg,   5'b10110);
    check("pending_owner", owner, 2);

    // Pointer now 3: requests 0 and 2 -> scan 3,0 -> 0 wins. Grant 2 times out.
    req = 4'b0101;
    measure_busy(n, s);
    check("timeout_busy_len", n, HOLD + 1);
    check("timeout_one_start", s, 1);
    check("idle_gap", busy, 0);
    step();
    check("rotate_ack",   ack,   4'b0001);
    check("rotate_owner", owner, 0);
    check("rotate_msg",   msg,   5'b01010);
    req = 4'd0;
    measure_busy(n, s);

    // Round-robin from a fresh pointer.
    @(posedge clk); #1 rst = 1'b1;
    step();
    rst = 1'b0;
    req_msg = {5'd4, 5'd3, 5'd2, 5'd1};
    req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      wait_ack("rr");
      check("rr_order", ack, 4'b0001 << g);
      req = req & ~ack;
      measure_busy(n, s);
      check("rr_busy_len", n, HOLD + 1);
      if (g < 3) begin
        step();
        check("rr_gap_one_cycle", busy, 1);
      end
    end

    // Reset mid-WAIT, then verify the pointer restarted at 0.
    step();
    req_msg[9:5] = 5'b10011;
    req = 4'b0010;
    wait_ack("rst_grant");
    req = 4'd0;
    step();
    step();
    check("pre_reset_msg", msg, 5'b10011);
    #3 rst = 1'b1;
    #1;
    check("async_reset_outputs", {19'd0, msg, start, ack, busy, owner}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    req = 4'b1010;             // ptr=0 -> 1 wins (ptr=2 would pick 3)
    step();
    check("post_reset_owner", owner, 1);
    check("post_reset_ack",   ack,   4'b0010);
    req = 4'd0;
    measure_busy(n, s);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
